// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcode/NOP constants,
// default PC width and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int PC_WIDTH_DEF = 16;
  localparam int INST_W       = 16;

  localparam logic [3:0]        OP_NOP   = 4'b0000;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ready;
  logic [INST_W-1:0]   imem_data;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_data);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_data);
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc, valid} holding register. Catches a word that
// completes while decode is stalled on a full IF/ID slot.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic                pop,
  input  logic [INST_W-1:0]   in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic [INST_W-1:0]   out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_valid
);

  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_WIDTH-1:0] pc_q,   pc_d;
  logic                vld_q,  vld_d;

  // Next entry: emptying (clear/pop) wins over a load in the same cycle.
  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    vld_d  = vld_q;
    if (clear || pop) begin
      vld_d  = 1'b0;
      inst_d = NOP_INST;
    end else if (load) begin
      inst_d = in_inst;
      pc_d   = in_pc;
      vld_d  = 1'b1;
    end
  end

  // Entry register; only the valid flag needs a reset value.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
  assign out_valid = vld_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, fetch FSM (FETCH/DRAIN/HOLD),
// IF/ID pipeline register and a one-entry skid buffer for stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_stage_if.master       imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [INST_W-1:0]   IF_ID_Inst,
  output logic [PC_WIDTH-1:0] IF_ID_PC,
  output logic                IF_ID_Valid
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
  logic                vld_q, vld_d;

  logic                skid_load, skid_clear, skid_pop;
  logic [INST_W-1:0]   skid_inst;
  logic [PC_WIDTH-1:0] skid_pc;
  logic                skid_valid;
  logic                done;

  fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .pop       (skid_pop),
    .in_inst   (imem.imem_data),
    .in_pc     (pc_q),
    .out_inst  (skid_inst),
    .out_pc    (skid_pc),
    .out_valid (skid_valid)
  );

  // Request decoded from registered state only. In DRAIN pc_q still holds the
  // abandoned address because the redirect target is parked in pend_q.
  assign imem.imem_req  = !rst && (state_q != ST_HOLD);
  assign imem.imem_addr = pc_q;
  assign done           = imem.imem_req && imem.imem_ready;

  // Next-state, PC and IF/ID update; redirect outranks stall everywhere.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    inst_d     = inst_q;
    ifpc_d     = ifpc_q;
    vld_d      = vld_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_pop   = 1'b0;
    if (redirect) begin
      vld_d      = 1'b0;
      inst_d     = NOP_INST;
      skid_clear = 1'b1;
      pend_d     = redirect_pc;
    end
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if (done) pc_d = redirect_pc;
          else      state_d = ST_DRAIN;
        end else if (done) begin
          pc_d = pc_q + PC_WIDTH'(1);
          if (!stall || !vld_q) begin
            inst_d = imem.imem_data;
            ifpc_d = pc_q;
            vld_d  = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (!stall) begin
          vld_d  = 1'b0;
          inst_d = NOP_INST;
        end
      end
      ST_DRAIN: begin
        if (done) begin
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (!stall) begin
          inst_d   = skid_inst;
          ifpc_d   = skid_pc;
          vld_d    = skid_valid;
          skid_pop = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ifpc_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      vld_q   <= vld_d;
    end
  end

  assign IF_ID_Inst  = inst_q;
  assign IF_ID_PC    = ifpc_q;
  assign IF_ID_Valid = vld_q;

endmodule
